// File: rtl/fpu_issue_ctrl.sv
// Issue controller: accepts one add/sub request, drives a start-level FPU,
// waits for done or a timeout, then presents one response under backpressure.
module fpu_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        fpu_start,
    output logic [31:0] fpu_n1,
    output logic [31:0] fpu_n2,
    output logic        fpu_sel,
    input  logic [31:0] fpu_result,
    input  logic        fpu_done,
    input  logic        fpu_busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        RESP      = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                start_q, start_d;
    logic [DATA_W-1:0]   n1_q, n1_d;
    logic [DATA_W-1:0]   n2_q, n2_d;
    logic                sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                ready_int;

    // Busy is status only and never steers sequencing.
    logic unused_busy;
    assign unused_busy = fpu_busy;

    // Hold off issue while the FPU is still showing done from the previous op.
    assign ready_int = (state_q == IDLE) && !fpu_done;

    // Handshake levels are forced low during reset so an aborted op emits nothing.
    assign req_ready = ready_int && !rst;
    assign fpu_start = start_q && !rst;
    assign rsp_valid = valid_q && !rst;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign fpu_n1    = n1_q;
    assign fpu_n2    = n2_q;
    assign fpu_sel   = sel_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            n1_q    <= '0;
            n2_q    <= '0;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            n1_q    <= n1_d;
            n2_q    <= n2_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        n1_d    = n1_q;
        n2_d    = n2_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && ready_int) begin
                    n1_d    = req_a;
                    n2_d    = req_b;
                    sel_d   = req_op;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (fpu_done) begin
                    data_d  = fpu_result;
                    err_d   = 1'b0;
                    start_d = 1'b0;
                    valid_d = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        start_d = 1'b0;
                        valid_d = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                start_d = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a behavioural start/done FPU model.
module tb_fpu_issue_ctrl;

    localparam int unsigned FPU_LAT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        req_op = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        fpu_start;
    logic [31:0] fpu_n1;
    logic [31:0] fpu_n2;
    logic        fpu_sel;
    logic [31:0] fpu_result;
    logic        fpu_done;
    logic        fpu_busy;
    logic        stuck = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    fpu_issue_ctrl #(.TIMEOUT_CYCLES(31)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .fpu_start(fpu_start), .fpu_n1(fpu_n1), .fpu_n2(fpu_n2), .fpu_sel(fpu_sel),
        .fpu_result(fpu_result), .fpu_done(fpu_done), .fpu_busy(fpu_busy)
    );

    always #5 clk = ~clk;

    // Known single-precision results for the operand pairs used here.
    function automatic logic [31:0] calc(input logic [31:0] a, input logic [31:0] b, input logic s);
        case ({s, a, b})
            {1'b0, 32'h3F800000, 32'h40000000}: calc = 32'h40400000; // 1+2
            {1'b1, 32'h40400000, 32'h3F800000}: calc = 32'h40000000; // 3-1
            {1'b0, 32'h40000000, 32'h40000000}: calc = 32'h40800000; // 2+2
            {1'b1, 32'h40800000, 32'h3F800000}: calc = 32'h40400000; // 4-1
            {1'b0, 32'h3FC00000, 32'h3F000000}: calc = 32'h40000000; // 1.5+0.5
            default:                             calc = 32'hDEADBEEF;
        endcase
    endfunction

    // FPU model: latency after start, done held until start drops plus one extra cycle.
    int m_cnt;
    int m_lin;
    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_busy   <= 1'b0;
            fpu_done   <= 1'b0;
            fpu_result <= '0;
            m_cnt      <= 0;
            m_lin      <= 0;
        end else if (fpu_busy) begin
            if (m_cnt == FPU_LAT - 1) begin
                fpu_busy   <= 1'b0;
                fpu_done   <= 1'b1;
                fpu_result <= calc(fpu_n1, fpu_n2, fpu_sel);
                m_lin      <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (fpu_done) begin
            if (!fpu_start) begin
                if (m_lin == 1) fpu_done <= 1'b0;
                else m_lin <= m_lin + 1;
            end
        end else if (fpu_start && !stuck) begin
            fpu_busy <= 1'b1;
            m_cnt    <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, verify operand capture/stability and the response; hold cycles of backpressure.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] exp_d, input logic exp_e,
                         input int hold, output int start_cycles);
        bit acc = 0;
        bit seen = 0;
        int unstable = 0;
        int held_bad = 0;
        start_cycles = 0;
        rsp_ready = (hold == 0);
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check({tag, "_accept"}, 32'(acc), 32'd1);
        check({tag, "_start"}, 32'(fpu_start), 32'd1);
        check({tag, "_n1"}, fpu_n1, a);
        check({tag, "_n2"}, fpu_n2, b);
        check({tag, "_sel"}, 32'(fpu_sel), 32'(op));
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (fpu_start) begin
                start_cycles++;
                if (fpu_n1 !== a || fpu_n2 !== b || fpu_sel !== op) unstable++;
            end
            seen = rsp_valid;
        end
        check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
        check({tag, "_stable"}, 32'(unstable), 32'd0);
        check({tag, "_data"}, rsp_data, exp_d);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
        if (hold > 0) begin
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_data !== exp_d || req_ready) held_bad++;
            end
            check({tag, "_held"}, 32'(held_bad), 32'd0);
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_one_pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int sc;
        int no_rsp;
        logic [31:0] ba [4];
        logic [31:0] bb [4];
        logic        bo [4];
        logic [31:0] be [4];
        int idx, got, conflict, order_bad;
        bit acc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_start", 32'(fpu_start), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_n1", fpu_n1, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        do_op("add", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 0, sc);
        repeat (3) @(posedge clk); #1;
        do_op("sub", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 0, sc);
        repeat (3) @(posedge clk); #1;
        do_op("bp", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0, 10, sc);
        repeat (3) @(posedge clk); #1;

        // Timeout with a stuck FPU
        stuck = 1'b1;
        do_op("tmo", 32'h3F800000, 32'h40000000, 1'b0, 32'h00000000, 1'b1, 0, sc);
        check("tmo_start_cycles", 32'(sc), 32'd31);
        stuck = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Back-to-back with req_valid held high
        ba[0] = 32'h3F800000; bb[0] = 32'h40000000; bo[0] = 1'b0; be[0] = 32'h40400000;
        ba[1] = 32'h40400000; bb[1] = 32'h3F800000; bo[1] = 1'b1; be[1] = 32'h40000000;
        ba[2] = 32'h40800000; bb[2] = 32'h3F800000; bo[2] = 1'b1; be[2] = 32'h40400000;
        ba[3] = 32'h3FC00000; bb[3] = 32'h3F000000; bo[3] = 1'b0; be[3] = 32'h40000000;
        idx = 0; got = 0; conflict = 0; order_bad = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_a = ba[0]; req_b = bb[0]; req_op = bo[0];
        for (int c = 0; c < 400 && got < 4; c++) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            if (req_ready && fpu_done) conflict++;
            if (rsp_valid && rsp_ready) begin
                if (rsp_data !== be[got] || rsp_err) order_bad++;
                got++;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    req_a = ba[idx]; req_b = bb[idx]; req_op = bo[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        check("b2b_accepts", 32'(idx), 32'd4);
        check("b2b_responses", 32'(got), 32'd4);
        check("b2b_order", 32'(order_bad), 32'd0);
        check("b2b_ready_vs_done", 32'(conflict), 32'd0);
        repeat (4) @(posedge clk); #1;

        // Reset three cycles after acceptance
        req_valid = 1'b1; req_a = 32'h3F800000; req_b = 32'h40000000; req_op = 1'b0;
        acc = 0;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("mid_accept", 32'(acc), 32'd1);
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        #1;
        check("mid_rst_start", 32'(fpu_start), 32'd0);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("mid_rst_start2", 32'(fpu_start), 32'd0);
        check("mid_rst_valid2", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        no_rsp = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) no_rsp++;
        end
        check("mid_no_rsp", 32'(no_rsp), 32'd0);
        @(posedge clk); #1;
        do_op("after_rst", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 0, sc);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
